// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM stage servicing LDR/STR over a 16-bit SRAM
//
// Each 32-bit access is split into a low and a high half-word phase of
// PHASE_CYCLES cycles each. The pipeline is frozen (ready=0) until the DONE cycle.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-low reset
//   writeBackEnIn, memReadIn,
//   memWriteIn, addressIn,
//   storeValueIn, destinationIn  EX/MEM register contents
//   writeBackEn, memRead         to MEM/WB, gated by ready
//   address, destination         pass-through to MEM/WB
//   memOut                       registered load data
//   ready, freeze                stage complete / pipeline stall (freeze = ~ready)
//   sram_addr, sram_we_n,
//   sram_dq_out, sram_dq_oe,
//   sram_dq_in                   external half-word SRAM interface
module mem_stage_sram_ctrl #(
    parameter int PHASE_CYCLES = 3,
    parameter int MEM_BASE     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeBackEnIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [31:0] addressIn,
    input  logic [31:0] storeValueIn,
    input  logic [3:0]  destinationIn,
    output logic        writeBackEn,
    output logic        memRead,
    output logic [31:0] address,
    output logic [31:0] memOut,
    output logic [3:0]  destination,
    output logic        ready,
    output logic        freeze,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    localparam int CNT_W = $clog2(PHASE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [31:0]        mem_out_q, mem_out_d;
    logic [17:0]        sram_addr_q, sram_addr_d;
    logic               sram_we_n_q, sram_we_n_d;
    logic [15:0]        sram_dq_out_q, sram_dq_out_d;
    logic               sram_dq_oe_q, sram_dq_oe_d;

    logic               phase_last;
    logic               wr_d, acc_d, hi_d;
    logic [31:0]        offset;
    logic [16:0]        word;
    logic               unused_offset_bits;

    // Modular subtraction; the word index is simply truncated, no range check.
    assign offset             = addressIn - 32'(MEM_BASE);
    assign word               = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    assign phase_last = (counter_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        mem_out_d = mem_out_q;
        case (state_q)
            IDLE: begin
                counter_d = '0;
                if (memReadIn) begin
                    state_d = RD_LO;
                end else if (memWriteIn) begin
                    state_d = WR_LO;
                end
            end
            RD_LO, RD_HI, WR_LO, WR_HI: begin
                if (phase_last) begin
                    counter_d = '0;
                    case (state_q)
                        RD_LO: begin
                            mem_out_d[15:0] = sram_dq_in;
                            state_d         = RD_HI;
                        end
                        RD_HI: begin
                            mem_out_d[31:16] = sram_dq_in;
                            state_d          = DONE;
                        end
                        WR_LO:   state_d = WR_HI;
                        default: state_d = DONE;
                    endcase
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                counter_d = '0;
            end
            default: begin
                state_d   = IDLE;
                counter_d = '0;
            end
        endcase
    end

    // SRAM pins are decoded from the next state so they are registered yet
    // line up with the cycle the FSM actually occupies that state.
    always_comb begin
        wr_d  = (state_d == WR_LO) || (state_d == WR_HI);
        acc_d = wr_d || (state_d == RD_LO) || (state_d == RD_HI);
        hi_d  = (state_d == RD_HI) || (state_d == WR_HI);

        sram_addr_d   = acc_d ? {word, hi_d} : 18'd0;
        sram_dq_oe_d  = wr_d;
        // Strobe released on the final cycle so address/data are held past it.
        sram_we_n_d   = !(wr_d && (counter_d != CNT_LAST));
        sram_dq_out_d = 16'd0;
        if (state_d == WR_LO) begin
            sram_dq_out_d = storeValueIn[15:0];
        end else if (state_d == WR_HI) begin
            sram_dq_out_d = storeValueIn[31:16];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            counter_q     <= '0;
            mem_out_q     <= 32'd0;
            sram_addr_q   <= 18'd0;
            sram_we_n_q   <= 1'b1;
            sram_dq_out_q <= 16'd0;
            sram_dq_oe_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            mem_out_q     <= mem_out_d;
            sram_addr_q   <= sram_addr_d;
            sram_we_n_q   <= sram_we_n_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
        end
    end

    assign ready       = ((state_q == IDLE) && !memReadIn && !memWriteIn) || (state_q == DONE);
    assign freeze      = ~ready;
    assign writeBackEn = writeBackEnIn & ready;
    assign memRead     = memReadIn & ready;
    assign address     = addressIn;
    assign destination = destinationIn;
    assign memOut      = mem_out_q;
    assign sram_addr   = sram_addr_q;
    assign sram_we_n   = sram_we_n_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - scoreboard bench for mem_stage_sram_ctrl
module tb_mem_stage_sram_ctrl;

    localparam int PC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_in, rd_in, wr_in;
    logic [31:0] addr_in, store_in;
    logic [3:0]  dest_in;
    logic        wb_out, mr_out, ready, freeze;
    logic [31:0] addr_out, mem_out;
    logic [3:0]  dest_out;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_dq_oe;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        rd_in2;
    logic [31:0] addr_in2;
    logic        wb_out2, mr_out2, ready2, freeze2;
    logic [31:0] addr_out2, mem_out2;
    logic [3:0]  dest_out2;
    logic [17:0] sram_addr2;
    logic        sram_we_n2, sram_dq_oe2;
    logic [15:0] sram_dq_out2, sram_dq_in2;

    logic [15:0] sram_mem [0:262143];

    assign sram_dq_in  = sram_mem[sram_addr];
    assign sram_dq_in2 = sram_mem[sram_addr2];

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(.PHASE_CYCLES(PC), .MEM_BASE(1024)) u_dut (
        .clk(clk), .rst(rst),
        .writeBackEnIn(wb_in), .memReadIn(rd_in), .memWriteIn(wr_in),
        .addressIn(addr_in), .storeValueIn(store_in), .destinationIn(dest_in),
        .writeBackEn(wb_out), .memRead(mr_out), .address(addr_out),
        .memOut(mem_out), .destination(dest_out), .ready(ready), .freeze(freeze),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    mem_stage_sram_ctrl #(.PHASE_CYCLES(2), .MEM_BASE(1024)) u_dut2 (
        .clk(clk), .rst(rst),
        .writeBackEnIn(1'b1), .memReadIn(rd_in2), .memWriteIn(1'b0),
        .addressIn(addr_in2), .storeValueIn(32'd0), .destinationIn(4'd7),
        .writeBackEn(wb_out2), .memRead(mr_out2), .address(addr_out2),
        .memOut(mem_out2), .destination(dest_out2), .ready(ready2), .freeze(freeze2),
        .sram_addr(sram_addr2), .sram_we_n(sram_we_n2), .sram_dq_out(sram_dq_out2),
        .sram_dq_oe(sram_dq_oe2), .sram_dq_in(sram_dq_in2)
    );

    typedef struct {
        int          start;
        int          lat;
        logic        is_load;
        logic [31:0] mem_val;
        logic        wb;
        logic [31:0] addr;
        logic [3:0]  dest;
    } resp_t;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    int    resp_count = 0;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops expected responses when ready, and expected SRAM writes on each strobe cycle.
    initial begin
        resp_t r;
        wr_t   w;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (resp_q.size() > 0) begin
                    if (ready) begin
                        r = resp_q.pop_front();
                        check("latency", cyc - r.start, r.lat);
                        check("writeBackEn", {31'd0, wb_out}, {31'd0, r.wb});
                        check("memRead", {31'd0, mr_out}, {31'd0, r.is_load});
                        check("address", addr_out, r.addr);
                        check("destination", {28'd0, dest_out}, {28'd0, r.dest});
                        if (r.is_load) check("memOut", mem_out, r.mem_val);
                        resp_count++;
                    end else begin
                        check("stall_wb", {31'd0, wb_out}, 32'd0);
                        check("stall_memread", {31'd0, mr_out}, 32'd0);
                        check("stall_freeze", {31'd0, freeze}, 32'd1);
                    end
                end
                if (!sram_we_n) begin
                    check("write_oe", {31'd0, sram_dq_oe}, 32'd1);
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", {14'd0, sram_addr}, 32'hFFFF_FFFF);
                    end else begin
                        w = wr_q.pop_front();
                        check("write_addr", {14'd0, sram_addr}, {14'd0, w.addr});
                        check("write_data", {16'd0, sram_dq_out}, {16'd0, w.data});
                    end
                    sram_mem[sram_addr] = sram_dq_out;
                end
            end
        end
    end

    task automatic push_writes(input logic [17:0] lo_addr, input logic [31:0] val, input int phases);
        wr_t w;
        for (int p = 0; p < phases; p++) begin
            for (int k = 0; k < PC - 1; k++) begin
                w.addr = lo_addr + 18'(p);
                w.data = (p == 0) ? val[15:0] : val[31:16];
                wr_q.push_back(w);
            end
        end
    endtask

    // Presents one op in the next cycle and waits for the monitor to retire it.
    task automatic issue(input logic rd, input logic wr, input logic wb, input logic [31:0] a,
                         input logic [31:0] sv, input logic [3:0] d, input logic [31:0] exp_mem,
                         input logic [17:0] exp_lo_addr);
        resp_t r;
        int    target;
        int    n;
        @(posedge clk);
        #1;
        rd_in = rd; wr_in = wr; wb_in = wb; addr_in = a; store_in = sv; dest_in = d;
        r.start   = cyc;
        r.lat     = (rd || wr) ? 2 * PC + 1 : 0;
        r.is_load = rd;
        r.mem_val = exp_mem;
        r.wb      = wb;
        r.addr    = a;
        r.dest    = d;
        if (wr && !rd) push_writes(exp_lo_addr, sv, 2);
        resp_q.push_back(r);
        target = resp_count + 1;
        n = 0;
        while (resp_count < target && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (resp_count < target) begin
            check("timeout", 32'd0, 32'd1);
            resp_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        rd_in = 1'b0; wr_in = 1'b0; wb_in = 1'b0; addr_in = 32'd0; store_in = 32'd0; dest_in = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int start;
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
        sram_mem[4]       = 16'h5678;
        sram_mem[5]       = 16'h1234;
        sram_mem[18'h3FFFE] = 16'h1111;
        sram_mem[18'h3FFFF] = 16'h2222;
        rst = 1'b0;
        rd_in = 1'b0; wr_in = 1'b0; wb_in = 1'b0; addr_in = 32'd0; store_in = 32'd0; dest_in = 4'd0;
        rd_in2 = 1'b0; addr_in2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_memOut", mem_out, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        rst = 1'b1;

        // ALU op: ready and write-back in the same cycle.
        issue(1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'd0, 4'h3, 32'd0, 18'd0);
        #1;
        check("alu_we_n", {31'd0, sram_we_n}, 32'd1);
        check("alu_oe", {31'd0, sram_dq_oe}, 32'd0);
        // STR 1028 -> half-words 2/3.
        issue(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 4'h0, 32'd0, 18'd2);
        // LDR 1028 back-to-back.
        issue(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'h5, 32'hDEAD_BEEF, 18'd0);
        // Read and write both requested: read wins, no writes expected.
        issue(1'b1, 1'b1, 1'b1, 32'd1032, 32'hFFFF_FFFF, 4'h6, 32'h1234_5678, 18'd0);
        // Address below MEM_BASE wraps to the top of the SRAM.
        issue(1'b1, 1'b0, 1'b1, 32'd1020, 32'd0, 4'h1, 32'h2222_1111, 18'd0);
        idle_cycle();
        // Back-to-back STR then LDR at 1036 -> half-words 6/7.
        issue(1'b0, 1'b1, 1'b0, 32'd1036, 32'hCAFE_F00D, 4'h2, 32'd0, 18'd6);
        issue(1'b1, 1'b0, 1'b1, 32'd1036, 32'd0, 4'h9, 32'hCAFE_F00D, 18'd0);
        idle_cycle();

        // Reset during WR_HI counter 0: only the low-half writes may reach the SRAM.
        @(posedge clk);
        #1;
        wr_in = 1'b1; addr_in = 32'd1040; store_in = 32'h0BAD_F00D; dest_in = 4'h4;
        push_writes(18'd8, 32'h0BAD_F00D, 1);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
        check("pre_rst_addr", {14'd0, sram_addr}, 32'd9);
        rst = 1'b0;
        #1;
        check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("midrst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("midrst_memOut", mem_out, 32'd0);
        wr_in = 1'b0; addr_in = 32'd0; store_in = 32'd0; dest_in = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, ready}, 32'd1);
        check("post_rst_memOut", mem_out, 32'd0);
        check("post_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("hi_half_unwritten", {16'd0, sram_mem[9]}, 32'd0);
        check("write_queue_empty", wr_q.size(), 32'd0);
        issue(1'b0, 1'b0, 1'b1, 32'h0000_00AA, 32'd0, 4'hC, 32'd0, 18'd0);
        idle_cycle();

        // PHASE_CYCLES=2 instance: LDR 1028 completes at cycle 5.
        @(posedge clk);
        #1;
        rd_in2 = 1'b1; addr_in2 = 32'd1028;
        start = cyc;
        n = 0;
        @(negedge clk);
        while (!ready2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pc2_latency", cyc - start, 32'd5);
        check("pc2_memOut", mem_out2, 32'hDEAD_BEEF);
        check("pc2_memRead", {31'd0, mr_out2}, 32'd1);
        @(posedge clk);
        #1;
        rd_in2 = 1'b0;
        repeat (2) @(posedge clk);

        check("resp_queue_empty", resp_q.size(), 32'd0);
        check("write_queue_drained", wr_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
